// File: rtl/rpm_pkg.sv
// rpm_pkg: shared UART framing types, ASCII constants and frame byte selection
package rpm_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [39:0] ASCII_ZERO5 = 40'h3030303030;
  localparam int FRAME_BYTES = 7;
  function automatic logic [7:0] frame_byte(input logic [39:0] s, input logic [2:0] i);
    return 8'({s, ASCII_CR, ASCII_LF} >> {3'd6 - i, 3'b000});
  endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional baud generator, tick is the carry of a 16-bit phase accumulator
module baud_tick_gen #(
  parameter int unsigned INC = 151
) (
  input  logic clk_50,
  input  logic RST_n,
  input  logic clr,
  output logic tick
);
  logic [15:0] acc;
  logic [16:0] sum;
  always_comb begin
    sum = {1'b0, acc} + 17'(INC);
    tick = sum[16] & ~clr;
  end
  always_ff @(posedge clk_50 or negedge RST_n)
    if (!RST_n) acc <= '0;
    else acc <= clr ? 16'd0 : sum[15:0];
endmodule

// File: rtl/rpm_uart_tx.sv
// rpm_uart_tx: sends the 5-digit ASCII RPM word plus CR LF as 8N1 on change or periodic refresh
module rpm_uart_tx import rpm_pkg::*; #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD_INC = 151,
  parameter int unsigned REFRESH_CYC = 25_000_000
) (
  input  logic        clk_50,
  input  logic        RST_n,
  input  logic [39:0] DIGITS,
  output logic        TX,
  output logic        TX_BUSY,
  output logic        FRAME_DONE
);
  if (BAUD_INC == 0 || BAUD_INC > 65535 || CLK_HZ == 0) begin : g_bad_param
    $error("rpm_uart_tx: BAUD_INC must be 1..65535 and CLK_HZ nonzero");
  end
  tx_state_t state, state_nxt;
  logic [39:0] dig_q, last_sent, snap;
  logic [31:0] ref_cnt, ref_nxt;
  logic [2:0] bit_idx, byte_idx;
  logic [7:0] cur_byte;
  logic dig_v, ref_pend, ref_hit, launch, tick, baud_clr, last_bit, last_byte, done_q;
  baud_tick_gen #(.INC(BAUD_INC)) u_baud (
    .clk_50(clk_50),
    .RST_n(RST_n),
    .clr(baud_clr),
    .tick(tick)
  );
  // dig_v keeps the zero reset value of dig_q from looking like a change
  always_comb begin
    baud_clr = state == IDLE;
    launch = state == IDLE && dig_v && (dig_q != last_sent || ref_pend);
    ref_nxt = (REFRESH_CYC != 0 && ref_cnt < REFRESH_CYC - 1) ? ref_cnt + 32'd1 : ref_cnt;
    ref_hit = REFRESH_CYC != 0 && ref_nxt == REFRESH_CYC - 1;
    last_bit = bit_idx == 3'd7;
    last_byte = byte_idx == 3'(FRAME_BYTES - 1);
    cur_byte = frame_byte(snap, byte_idx);
  end
  always_ff @(posedge clk_50 or negedge RST_n)
    if (!RST_n) begin
      dig_q <= '0;
      dig_v <= 1'b0;
      snap <= '0;
      last_sent <= ASCII_ZERO5;
      ref_cnt <= '0;
      ref_pend <= 1'b0;
    end else begin
      dig_q <= DIGITS;
      dig_v <= 1'b1;
      ref_cnt <= launch ? 32'd0 : ref_nxt;
      ref_pend <= !launch && (ref_pend || ref_hit);
      if (launch) begin
        snap <= dig_q;
        last_sent <= dig_q;
      end
    end
  always_ff @(posedge clk_50 or negedge RST_n)
    if (!RST_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = launch ? START :
                !tick ? state :
                state == START ? DATA :
                state == DATA ? (last_bit ? STOP : DATA) :
                state == STOP ? (last_byte ? IDLE : START) : state;
  always_ff @(posedge clk_50 or negedge RST_n)
    if (!RST_n) begin
      bit_idx <= '0;
      byte_idx <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == STOP && tick && last_byte;
      byte_idx <= launch ? 3'd0 : (state == STOP && tick && !last_byte) ? byte_idx + 3'd1 : byte_idx;
      bit_idx <= state == START ? 3'd0 : (state == DATA && tick && !last_bit) ? bit_idx + 3'd1 : bit_idx;
    end
  always_comb begin
    TX = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
    TX_BUSY = state != IDLE;
    FRAME_DONE = done_q;
  end
endmodule

// File: tb/tb_rpm_uart_tx.sv
// tb_rpm_uart_tx: randomized frame checks of rpm_uart_tx against a bit-boundary reference model
module tb_rpm_uart_tx;
  localparam int unsigned INC = 1500;
  localparam int unsigned RC = 5000;
  localparam int LIM = int'(RC) + 4000;
  localparam logic [39:0] Z5 = 40'h3030303030;
  localparam logic [39:0] D01234 = 40'h3031323334;
  localparam logic [39:0] D00600 = 40'h3030363030;
  logic clk_50 = 1'b0;
  logic RST_n = 1'b0;
  logic [39:0] DIGITS = Z5;
  logic TX, TX_BUSY, FRAME_DONE;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int last_l = 0;
  int bnd [0:70];
  rpm_uart_tx #(.BAUD_INC(INC), .REFRESH_CYC(RC)) dut (
    .clk_50(clk_50),
    .RST_n(RST_n),
    .DIGITS(DIGITS),
    .TX(TX),
    .TX_BUSY(TX_BUSY),
    .FRAME_DONE(FRAME_DONE)
  );
  always #10 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;
  function automatic logic [7:0] ref_byte(input logic [39:0] d, input int i);
    if (i < 5) return d[8*(4-i) +: 8];
    return (i == 5) ? 8'h0D : 8'h0A;
  endfunction
  // line level expected n clocks after the launch edge: bit k spans [bnd[k], bnd[k+1])
  function automatic logic ref_bit(input logic [39:0] d, input int n);
    int k;
    logic [7:0] b;
    k = 0;
    while (k < 69 && bnd[k+1] <= n) k++;
    b = ref_byte(d, k / 10);
    if (k % 10 == 0) return 1'b0;
    if (k % 10 == 9) return 1'b1;
    return b[k % 10 - 1];
  endfunction
  function automatic logic [39:0] rand_new(input logic [39:0] cur);
    logic [39:0] v;
    do begin
      for (int i = 0; i < 5; i++) v[8*i +: 8] = 8'h30 + 8'($urandom_range(0, 9));
    end while (v == cur || v == D01234);
    return v;
  endfunction
  task automatic expect_frame(input logic [39:0] d, input string name, input int exp_l,
                              input int upd_n, input logic [39:0] upd_v, output int l);
    int w, etx, ebusy, edone;
    logic xt, xb, xd;
    w = 0; etx = 0; ebusy = 0; edone = 0; l = -1;
    do begin
      @(negedge clk_50);
      w++;
    end while (TX !== 1'b0 && w < LIM);
    compared++;
    if (TX !== 1'b0) begin
      mismatched++;
      $display("FAIL %s launch: TX=%b after %0d cycles, required 0", name, TX, w);
      return;
    end
    l = cyc;
    compared++;
    if (l !== exp_l) begin
      mismatched++;
      $display("FAIL %s launch cycle: got %0d required %0d", name, l, exp_l);
    end
    for (int n = 0; n <= bnd[70]; n++) begin
      if (n > 0) @(negedge clk_50);
      if (n == upd_n) DIGITS = upd_v;
      xt = (n < bnd[70]) ? ref_bit(d, n) : 1'b1;
      xb = n < bnd[70];
      xd = n == bnd[70];
      if (TX !== xt) begin
        if (etx == 0) $display("FAIL %s TX at +%0d: got %b required %b", name, n, TX, xt);
        etx++;
      end
      if (TX_BUSY !== xb) begin
        if (ebusy == 0) $display("FAIL %s TX_BUSY at +%0d: got %b required %b", name, n, TX_BUSY, xb);
        ebusy++;
      end
      if (FRAME_DONE !== xd) begin
        if (edone == 0) $display("FAIL %s FRAME_DONE at +%0d: got %b required %b", name, n, FRAME_DONE, xd);
        edone++;
      end
    end
    compared += 3;
    mismatched += int'(etx != 0) + int'(ebusy != 0) + int'(edone != 0);
  endtask
  task automatic test_reset;
    int c0, bad, l;
    RST_n = 1'b0;
    DIGITS = Z5;
    repeat (4) @(negedge clk_50);
    compared += 3;
    if (TX !== 1'b1) begin mismatched++; $display("FAIL reset TX: got %b required 1", TX); end
    if (TX_BUSY !== 1'b0) begin mismatched++; $display("FAIL reset TX_BUSY: got %b required 0", TX_BUSY); end
    if (FRAME_DONE !== 1'b0) begin mismatched++; $display("FAIL reset FRAME_DONE: got %b required 0", FRAME_DONE); end
    RST_n = 1'b1;
    c0 = cyc;
    bad = 0;
    for (int i = 0; i < int'(RC) - 10; i++) begin
      @(negedge clk_50);
      if (TX !== 1'b1 || FRAME_DONE !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL reset_idle: %0d active cycles, required 0", bad); end
    expect_frame(Z5, "refresh_after_reset", c0 + int'(RC), -1, Z5, l);
    last_l = l;
  endtask
  task automatic test_value_change;
    logic [39:0] v;
    int l;
    v = D01234;
    for (int t = 0; t < 4; t++) begin
      DIGITS = v;
      expect_frame(v, "value_change", cyc + 2, -1, v, l);
      last_l = l;
      v = rand_new(v);
    end
  endtask
  task automatic test_mid_frame;
    int l;
    DIGITS = D01234;
    expect_frame(D01234, "mid_first", cyc + 2, bnd[20] + 10, D00600, l);
    expect_frame(D00600, "mid_second", l + bnd[70] + 1, -1, D00600, l);
    last_l = l;
  endtask
  task automatic test_refresh;
    int l;
    for (int t = 0; t < 2; t++) begin
      expect_frame(DIGITS, "refresh", last_l + int'(RC), -1, DIGITS, l);
      last_l = l;
    end
  endtask
  task automatic test_simultaneous;
    logic [39:0] v;
    int l;
    v = rand_new(DIGITS);
    while (cyc < last_l + int'(RC) - 2) @(negedge clk_50);
    DIGITS = v;
    expect_frame(v, "simul_change_refresh", last_l + int'(RC), -1, v, l);
    expect_frame(v, "simul_next_refresh", l + int'(RC), -1, v, l);
    last_l = l;
  endtask
  task automatic test_reset_mid_frame;
    logic [39:0] v;
    int w, bad;
    v = rand_new(DIGITS);
    DIGITS = v;
    w = 0;
    do begin
      @(negedge clk_50);
      w++;
    end while (TX !== 1'b0 && w < LIM);
    compared++;
    if (TX !== 1'b0) begin mismatched++; $display("FAIL rst_mid launch: TX=%b required 0", TX); end
    repeat (bnd[40] + 7) @(negedge clk_50);
    DIGITS = Z5;
    RST_n = 1'b0;
    #1;
    compared += 3;
    if (TX !== 1'b1) begin mismatched++; $display("FAIL rst_mid TX: got %b required 1", TX); end
    if (TX_BUSY !== 1'b0) begin mismatched++; $display("FAIL rst_mid TX_BUSY: got %b required 0", TX_BUSY); end
    if (FRAME_DONE !== 1'b0) begin mismatched++; $display("FAIL rst_mid FRAME_DONE: got %b required 0", FRAME_DONE); end
    repeat (3) @(negedge clk_50);
    RST_n = 1'b1;
    bad = 0;
    for (int i = 0; i < int'(RC) - 10; i++) begin
      @(negedge clk_50);
      if (TX !== 1'b1 || TX_BUSY !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL rst_mid_idle: %0d active cycles, required 0", bad); end
  endtask
  initial begin
    for (int k = 0; k <= 70; k++) bnd[k] = int'((longint'(k) * 65536 + longint'(INC) - 1) / longint'(INC));
    test_reset;
    test_value_change;
    test_mid_frame;
    test_refresh;
    test_simultaneous;
    test_reset_mid_frame;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
